// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: buffers one 16-word block, then streams W_0..W_(ROUNDS-1)
// to the compression engine through a valid/ready handshake.
module sha256_msg_schedule #(
   parameter int ROUNDS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic [31:0] m_i,
   input  logic        w_ready_i,
   output logic        w_valid_o,
   output logic [31:0] w_o,
   output logic [5:0]  t_o,
   output logic        last_o,
   output logic        busy_o,
   output logic        err_o
);

   typedef enum logic {LOAD, EMIT} state_e;

   localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);
   localparam logic [6:0] T_END  = 7'(ROUNDS);

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic [31:0] win_q [16];
   logic        w_valid_q;
   logic [5:0]  t_q;
   logic        err_q;
   logic [31:0] w_new_d;

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   // Next window word W_(t+16); past the last round only zeros are shifted in.
   always_comb begin
      // NOTE: default first so every path assigns w_new_d and no latch is inferred.
      w_new_d = '0;
      if (({1'b0, t_q} + 7'd16) < T_END)
         w_new_d = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
   end

   // NOTE: all state updates use non-blocking assignments so the window shift reads pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= LOAD;
         cnt_q     <= '0;
         // NOTE: the window is a small register file, so it is reset to give w_o a defined zero.
         for (int i = 0; i < 16; i++) win_q[i] <= '0;
         w_valid_q <= 1'b0;
         t_q       <= '0;
         err_q     <= 1'b0;
      end else begin
         case (state_q)
            LOAD: begin
               if (valid_i) begin
                  for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
                  win_q[15] <= m_i;
                  if (cnt_q == 4'd15) begin
                     cnt_q     <= '0;
                     state_q   <= EMIT;
                     w_valid_q <= 1'b1;
                     t_q       <= '0;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end
            end
            EMIT: begin
               // Upstream cannot be stalled, so any word arriving now is lost.
               if (valid_i) err_q <= 1'b1;
               if (w_valid_q && w_ready_i) begin
                  for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
                  win_q[15] <= w_new_d;
                  if (t_q == T_LAST) begin
                     w_valid_q <= 1'b0;
                     t_q       <= '0;
                     state_q   <= LOAD;
                  end else begin
                     t_q <= t_q + 6'd1;
                  end
               end
            end
            default: state_q <= LOAD;
         endcase
      end
   end

   assign w_valid_o = w_valid_q;
   assign w_o       = win_q[0];
   assign t_o       = t_q;
   assign last_o    = w_valid_q & (t_q == T_LAST);
   assign busy_o    = (state_q == EMIT);
   assign err_o     = err_q;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Randomised scoreboard bench for sha256_msg_schedule: a reference schedule model
// pushes expected words, a monitor pops and compares on every accepted transfer.
module tb_sha256_msg_schedule;

   localparam int ROUNDS = 64;

   typedef logic [31:0] blk_t [16];
   typedef struct packed {
      logic [31:0] w;
      logic [5:0]  t;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i;
   logic [31:0] m_i;
   logic        w_ready_i;
   logic        w_valid_o;
   logic [31:0] w_o;
   logic [5:0]  t_o;
   logic        last_o;
   logic        busy_o;
   logic        err_o;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   sha256_msg_schedule #(.ROUNDS(ROUNDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .valid_i   (valid_i),
      .m_i       (m_i),
      .w_ready_i (w_ready_i),
      .w_valid_o (w_valid_o),
      .w_o       (w_o),
      .t_o       (t_o),
      .last_o    (last_o),
      .busy_o    (busy_o),
      .err_o     (err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h (time %0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction

   // Reference: the textbook SHA-256 schedule recurrence over a full array.
   task automatic expect_block(input blk_t b);
      logic [31:0] w [64];
      exp_t e;
      for (int t = 0; t < ROUNDS; t++) begin
         if (t < 16) w[t] = b[t];
         else w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
         e.w    = w[t];
         e.t    = 6'(t);
         e.last = (t == ROUNDS - 1);
         sb_q.push_back(e);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst && w_valid_o && w_ready_i) begin
         if (sb_q.size() == 0) begin
            check("unexpected_word", w_o, 32'hxxxx_xxxx);
         end else begin
            e = sb_q.pop_front();
            check($sformatf("w_t%0d", e.t), w_o, e.w);
            check("t_index", {26'd0, t_o}, {26'd0, e.t});
            check($sformatf("last_t%0d", e.t), {31'd0, last_o}, {31'd0, e.last});
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_blk(output blk_t b);
      for (int i = 0; i < 16; i++) b[i] = $urandom;
   endtask

   task automatic feed(input blk_t b, input bit gaps);
      expect_block(b);
      for (int i = 0; i < 16; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
               valid_i = 1'b0;
               m_i     = $urandom;
               cyc();
            end
         end
         if (i == 15) check("premature_emit", {31'd0, w_valid_o}, 32'd0);
         valid_i = 1'b1;
         m_i     = b[i];
         cyc();
      end
      valid_i = 1'b0;
      check("emit_latency", {31'd0, w_valid_o}, 32'd1);
      check("emit_t0", {26'd0, t_o}, 32'd0);
      check("busy_emit", {31'd0, busy_o}, 32'd1);
   endtask

   task automatic wait_t(input int t);
      int k = 0;
      while (!(w_valid_o && t_o == 6'(t)) && k < 3000) begin
         cyc();
         k++;
      end
      check($sformatf("reach_t%0d", t), {31'd0, (k < 3000)}, 32'd1);
   endtask

   task automatic wait_drain(input bit rand_rdy);
      int k = 0;
      while (k < 3000) begin
         cyc();
         k++;
         if (sb_q.size() == 0) break;
         if (rand_rdy) w_ready_i = 1'($urandom_range(0, 1));
      end
      w_ready_i = 1'b1;
      check("drain", {31'd0, (k < 3000)}, 32'd1);
      check("valid_after_last", {31'd0, w_valid_o}, 32'd0);
      check("busy_after_last", {31'd0, busy_o}, 32'd0);
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_valid"}, {31'd0, w_valid_o}, 32'd0);
      check({tag, "_w"}, w_o, 32'd0);
      check({tag, "_t"}, {26'd0, t_o}, 32'd0);
      check({tag, "_last"}, {31'd0, last_o}, 32'd0);
      check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
      check({tag, "_err"}, {31'd0, err_o}, 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got running expected finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      blk_t abc, b, b2;
      logic [31:0] hold_w;
      int k;

      rst       = 1'b0;
      valid_i   = 1'b0;
      m_i       = '0;
      w_ready_i = 1'b1;
      repeat (3) cyc();
      check_idle_zero("reset");
      rst = 1'b1;
      cyc();

      // "abc" block
      for (int i = 0; i < 16; i++) abc[i] = '0;
      abc[0]  = 32'h6162_6380;
      abc[15] = 32'h0000_0018;
      feed(abc, 1'b0);
      check("abc_w0", w_o, 32'h6162_6380);
      wait_drain(1'b0);

      // Stall at t=20
      rand_blk(b);
      feed(b, 1'b0);
      wait_t(20);
      w_ready_i = 1'b0;
      hold_w    = w_o;
      repeat (5) begin
         cyc();
         check("stall_w", w_o, hold_w);
         check("stall_t", {26'd0, t_o}, 32'd20);
         check("stall_valid", {31'd0, w_valid_o}, 32'd1);
      end
      w_ready_i = 1'b1;
      wait_drain(1'b0);

      // Same block gapless then gapped
      rand_blk(b);
      feed(b, 1'b0);
      wait_drain(1'b0);
      feed(b, 1'b1);
      wait_drain(1'b0);

      // Random backpressure
      rand_blk(b);
      feed(b, 1'b1);
      wait_drain(1'b1);

      // Overflow at t=30 and on the final transfer
      rand_blk(b);
      feed(b, 1'b0);
      wait_t(30);
      valid_i = 1'b1;
      m_i     = $urandom;
      cyc();
      valid_i = 1'b0;
      check("err_set", {31'd0, err_o}, 32'd1);
      wait_t(63);
      valid_i = 1'b1;
      m_i     = $urandom;
      cyc();
      valid_i = 1'b0;
      check("final_xfer_drained", sb_q.size(), 32'd0);
      check("final_xfer_valid", {31'd0, w_valid_o}, 32'd0);
      rand_blk(b);
      feed(b, 1'b0);
      wait_drain(1'b0);
      check("err_sticky", {31'd0, err_o}, 32'd1);

      // Reset mid-emission at t=40
      rand_blk(b);
      feed(b, 1'b0);
      wait_t(40);
      rst = 1'b0;
      #2;
      check_idle_zero("mid_reset");
      sb_q.delete();
      cyc();
      cyc();
      rst = 1'b1;
      cyc();
      rand_blk(b);
      feed(b, 1'b1);
      wait_drain(1'b0);

      // Back-to-back blocks
      rand_blk(b);
      rand_blk(b2);
      feed(b, 1'b0);
      k = 0;
      while (!(w_valid_o && last_o) && k < 3000) begin
         cyc();
         k++;
      end
      check("b2b_reach_last", {31'd0, (k < 3000)}, 32'd1);
      cyc();
      feed(b2, 1'b0);
      wait_drain(1'b0);
      check("b2b_no_drop", {31'd0, err_o}, 32'd0);

      repeat (3) cyc();
      check("sb_empty", sb_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sha256_msg_schedule.md
Name: sha256_msg_schedule

Overview:
Consumes the 32-bit padded-block word stream produced by the SHA-256 preprocessor (valid + 32-bit word, 16 consecutive words per 512-bit block, MSB-first big-endian words). It buffers one block in a 16-entry sliding window. It then emits the message schedule W_0..W_(ROUNDS-1), one word per accepted handshake, to the compression engine, with a round index. Sits between the preprocessor and the round/compression datapath.

Parameters:
ROUNDS, 64, number of W_t words emitted per block; legal range 16..64, and 64 for SHA-256 compliance.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
valid_i  input  1  upstream word valid; no backpressure exists upstream
m_i  input  32  upstream block word, word 0 first
w_ready_i  input  1  compression engine ready for next W_t
w_valid_o  output  1  W_t valid
w_o  output  32  schedule word W_t
t_o  output  6  round index t of w_o
last_o  output  1  high while w_valid_o=1 and t_o=ROUNDS-1
busy_o  output  1  high in EMIT state
err_o  output  1  sticky: upstream word dropped

Behaviour:
- Reset (rst=0, async): state=LOAD, load count=0, window[0..15]=0, w_valid_o=0, w_o=0, t_o=0, last_o=0, busy_o=0, err_o=0. Reset mid-block or mid-emission discards everything, with no partial output.
- State LOAD:
  - On each clk with valid_i=1: window shifts down (win[i]<=win[i+1], win[15]<=m_i) and count increments. valid_i=0 cycles are gaps; the count holds.
  - On the 16th accepted word: win[0]=word0 … win[15]=word15, count<=0, state<=EMIT, w_valid_o<=1, t_o<=0 at the same edge. w_valid_o is high the cycle after the 16th word (latency 1).
  - w_ready_i is ignored in LOAD.
- State EMIT:
  - w_o is win[0]; w_o, t_o and w_valid_o are stable while w_ready_i=0.
  - Transfer occurs when w_valid_o && w_ready_i: window shifts down and t_o increments.
  - win[15] is loaded with W_(t+16) = σ1(win[14]) + win[9] + σ0(win[1]) + win[0], mod 2^32, computed from pre-shift values.
  - If t+16 >= ROUNDS, win[15] is loaded with 0.
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3; σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - On the transfer with t_o=ROUNDS-1: w_valid_o<=0, t_o<=0, state<=LOAD. A new block can be accepted starting the next cycle.
- Overflow: valid_i=1 in EMIT, including the cycle of the final transfer, drops the word, sets err_o<=1 (cleared only by reset), and leaves window and state unaffected.
- last_o = w_valid_o & (t_o==ROUNDS-1).
- busy_o = (state==EMIT).
- Back-to-back streaming: with w_ready_i held 1, a block occupies 16 load cycles plus ROUNDS emit cycles.

Test Plan:
- "abc" block: words 61626380, 14× 00000000, 00000018 → w_valid_o high 1 cycle after 16th word. Expected W_0=61626380, W_15=00000018, W_16=61626380, W_17=000F0000. 64 transfers with t_o 0..63, last_o only at t=63, and w_valid_o=0 the cycle after.
- Stall: w_ready_i=0 for 5 cycles at t=20 → w_o/t_o frozen, no word lost. Full sequence matches a golden model of the same block.
- Gapped load: 16 words with random valid_i gaps → identical W sequence to the gapless case, and emission begins 1 cycle after the final word.
- Overflow: pulse valid_i at t=30 of EMIT → err_o=1 and stays 1, W sequence unaltered. Next clean block loads correctly while err_o remains 1.
- Reset mid-EMIT at t=40, then a fresh 16-word block → all outputs 0 during reset, new block emitted from t=0 with correct values.
- Two consecutive blocks with w_ready_i=1 → second block's first word accepted the cycle after the last_o transfer, both schedules correct.
